life_sequencer: RTL and testbench
=================================

LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 SHALL have parameter map_width, default 8: side of the square cell map; N = map_width**2.
REQ-002 SHALL have parameter TICK_DIV, default 4: clock cycles per generation in free-run; legal range 2 or more.
REQ-003 SHALL have parameter GEN_W, default 16: width of the generation counter.
REQ-004 SHALL have parameter AUTO_HALT, default 1: when 1, free-run stops when the map is stable or extinct.
REQ-005 SHALL have port clock, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-007 SHALL have port run, input, 1: level; free-run while high.
REQ-008 SHALL have port step, input, 1: one-cycle pulse; advance exactly one generation.
REQ-009 SHALL have port load_req, input, 1: one-cycle pulse; load load_pattern into the map.
REQ-010 SHALL have port load_pattern, input, N: initial pattern; sampled only in the load_req cycle.
REQ-011 SHALL have port cur_state, input, N: current map contents, from the map register output.
REQ-012 SHALL have port next_state, input, N: next generation, from the combinational rule logic.
REQ-013 SHALL have port map_enable, output, 1: write enable to the map register.
REQ-014 SHALL have port map_state_in, output, N: data to the map register.
REQ-015 SHALL have port generation, output, GEN_W: number of committed generations since the last load or reset.
REQ-016 SHALL have port stable, output, 1: the last commit had next_state == cur_state.
REQ-017 SHALL have port extinct, output, 1: the last commit had next_state == 0.
REQ-018 SHALL have port halted, output, 1: high while in HALT.

Function
REQ-019 SHALL have FSM states IDLE, RUN, STEP, LOAD and HALT; it leaves reset in IDLE.
REQ-020 In any state, load_req SHALL have top priority: capture load_pattern into an internal N-bit register and go to LOAD.
REQ-021 LOAD SHALL last one cycle: map_enable=1, map_state_in = captured pattern, generation cleared, stable/extinct cleared; then IDLE.
REQ-022 In IDLE, run=1 SHALL go to RUN; otherwise step=1 SHALL go to STEP. run wins if both are high.
REQ-023 STEP SHALL last one cycle: one commit (REQ-026); then IDLE.
REQ-024 In RUN, a divider SHALL count 0..TICK_DIV-1 and wrap; a commit SHALL occur in the cycle when the divider equals TICK_DIV-1.
REQ-025 In RUN, run=0 SHALL go to IDLE and clear the divider; no commit occurs in that cycle.
REQ-026 A commit SHALL assert map_enable=1 with map_state_in=next_state for exactly one cycle, and at that edge:
  - generation increments, saturating at 2**GEN_W-1;
  - stable <= (next_state == cur_state);
  - extinct <= (next_state == 0).
REQ-027 With AUTO_HALT=1, a RUN commit that sets stable or extinct SHALL go to HALT; a STEP commit never halts.
REQ-028 HALT SHALL keep map_enable=0 and ignore run and step; it is left only via load_req.
REQ-029 Outside LOAD and commit cycles, map_enable SHALL be 0 and map_state_in SHALL equal next_state.
REQ-030 map_enable, generation, stable, extinct and halted SHALL be registered outputs.
REQ-031 Latency: step in cycle t SHALL give map_enable=1 in cycle t+1; load_req in cycle t SHALL give map_enable=1 in cycle t+1.

Reset
REQ-032 Asynchronous reset SHALL force IDLE, divider 0, map_enable 0, generation 0, stable 0, extinct 0, halted 0, and the captured pattern 0.
REQ-033 Reset mid-RUN or mid-LOAD SHALL produce no further map_enable pulse until a new run, step or load_req.

Structure
REQ-034 The FSM state encoding SHALL live in a shared package life_pkg, for reuse by the display controller.
REQ-035 The divider SHALL be a sub-module life_tick_div (inputs: clear, enable; output: tick pulse).
REQ-036 The map register and rule logic SHALL stay outside this block.

Verification (map_width=4, TICK_DIV=4, GEN_W=16, AUTO_HALT=1)
REQ-037 Load: load_req with pattern 16'h0660 -> map_enable 1 cycle later with map_state_in=16'h0660; generation=0.
REQ-038 Free-run: blinker 16'h0E00 with run held for 17 cycles -> 4 commits exactly 4 cycles apart; generation=4; stable=0.
REQ-039 Auto-halt: block 16'h0660 with run=1 -> first commit sets stable=1 and halted=1; no further map_enable while run stays high.
REQ-040 Extinction: single cell 16'h0001 with run=1 -> commit writes 0, extinct=1, halted=1; a later load_req clears both flags.
REQ-041 Priority: run and step in the same IDLE cycle -> RUN entered with no STEP commit; load_req in the same cycle as a RUN tick -> LOAD wins, generation=0.
REQ-042 Reset during RUN at divider=2 -> all outputs 0 immediately; no map_enable until the next command.

Source files
------------

// File: rtl/life_pkg.sv
// Shared encoding of the life sequencer FSM, also decoded by the display controller.
package life_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_LOAD = 3'd3,
    S_HALT = 3'd4
  } life_state_e;

endpackage

// File: rtl/life_tick_div.sv
// Generation-rate divider: counts 0..TICK_DIV-1 while enabled and pulses one cycle
// before the terminal count, so the registered map write lands on the terminal cycle.
module life_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && !clear && (cnt_q == CW'(TICK_DIV - 2));

endmodule

// File: rtl/life_sequencer.sv
// Sequencer for an external Game-of-Life map register: load, single step, free-run
// with optional auto-halt on stable or extinct maps.
//
//   state  | meaning
//   IDLE   | waiting for run, step or load_req
//   RUN    | free-run, one commit every TICK_DIV cycles
//   STEP   | single commit cycle
//   LOAD   | writing the captured pattern into the map
//   HALT   | auto-halted; only load_req leaves
module life_sequencer
  import life_pkg::*;
#(
  parameter  int map_width = 8,
  parameter  int TICK_DIV  = 4,
  parameter  int GEN_W     = 16,
  parameter  int AUTO_HALT = 1,
  localparam int N         = map_width * map_width
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             load_req,
  input  logic [N-1:0]     load_pattern,
  input  logic [N-1:0]     cur_state,
  input  logic [N-1:0]     next_state,
  output logic             map_enable,
  output logic [N-1:0]     map_state_in,
  output logic [GEN_W-1:0] generation,
  output logic             stable,
  output logic             extinct,
  output logic             halted
);

  life_state_e      state_q, state_d;
  logic [N-1:0]     pattern_q;
  logic             map_en_q, map_en_d;
  logic [GEN_W-1:0] gen_q;
  logic             stable_q, extinct_q, halted_q;
  logic             commit, same_w, empty_w;
  logic             div_enable, div_clear, tick;

  // map_en_q high outside LOAD marks the cycle in which next_state is being written
  assign commit  = map_en_q && (state_q == S_RUN || state_q == S_STEP);
  assign same_w  = (next_state == cur_state);
  assign empty_w = (next_state == '0);

  always_comb begin
    state_d = state_q;
    if (load_req) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run)       state_d = S_RUN;
          else if (step) state_d = S_STEP;
        end
        S_RUN: begin
          if (!run) begin
            state_d = S_IDLE;
          end else if (commit && (AUTO_HALT != 0) && (same_w || empty_w)) begin
            state_d = S_HALT;
          end
        end
        S_STEP:  state_d = S_IDLE;
        S_LOAD:  state_d = S_IDLE;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign div_enable = (state_q == S_RUN);
  assign div_clear  = (state_d != S_RUN);

  life_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clock  (clock),
    .reset  (reset),
    .clear  (div_clear),
    .enable (div_enable),
    .tick   (tick)
  );

  assign map_en_d = (state_d == S_LOAD) || (state_d == S_STEP) || tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      map_en_q  <= 1'b0;
      gen_q     <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      map_en_q <= map_en_d;
      halted_q <= (state_d == S_HALT);
      if (load_req) begin
        pattern_q <= load_pattern;
      end
      if (state_q == S_LOAD) begin
        gen_q     <= '0;
        stable_q  <= 1'b0;
        extinct_q <= 1'b0;
      end else if (commit) begin
        if (gen_q != '1) begin
          gen_q <= gen_q + GEN_W'(1);
        end
        stable_q  <= same_w;
        extinct_q <= empty_w;
      end
    end
  end

  assign map_enable   = map_en_q;
  assign map_state_in = (state_q == S_LOAD) ? pattern_q : next_state;
  assign generation   = gen_q;
  assign stable       = stable_q;
  assign extinct      = extinct_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Scoreboarded bench for life_sequencer on a 4x4 map with a non-wrapping Life rule.
module tb_life_sequencer;

  localparam int MW = 4;
  localparam int TD = 4;
  localparam int GW = 16;
  localparam int NB = MW * MW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0, step = 1'b0, load_req = 1'b0;
  logic [NB-1:0] load_pattern = '0;
  logic [NB-1:0] cur_state, next_state, map_state_in;
  logic          map_enable, stable, extinct, halted;
  logic [GW-1:0] generation;

  logic [NB-1:0] map_q = '0;
  int            n_pass = 0, n_total = 0, cyc_cnt = 0;
  logic [NB-1:0] exp_q[$];
  int            wr_cyc[$];

  logic [NB-1:0] m_map = '0;
  logic [GW-1:0] m_gen = '0;
  bit            m_stable = 0, m_extinct = 0, m_halted = 0;

  always #5 clock = ~clock;

  life_sequencer #(
    .map_width (MW),
    .TICK_DIV  (TD),
    .GEN_W     (GW),
    .AUTO_HALT (1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .step         (step),
    .load_req     (load_req),
    .load_pattern (load_pattern),
    .cur_state    (cur_state),
    .next_state   (next_state),
    .map_enable   (map_enable),
    .map_state_in (map_state_in),
    .generation   (generation),
    .stable       (stable),
    .extinct      (extinct),
    .halted       (halted)
  );

  function automatic logic [NB-1:0] life_next(input logic [NB-1:0] m);
    logic [NB-1:0] r;
    int n, yy, xx;
    r = '0;
    for (int y = 0; y < MW; y++) begin
      for (int x = 0; x < MW; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            yy = y + dy;
            xx = x + dx;
            if ((dy != 0 || dx != 0) && yy >= 0 && yy < MW && xx >= 0 && xx < MW)
              if (m[yy*MW + xx]) n++;
          end
        end
        r[y*MW + x] = (n == 3) || (m[y*MW + x] && n == 2);
      end
    end
    return r;
  endfunction

  assign cur_state  = map_q;
  assign next_state = life_next(map_q);

  always @(posedge clock) begin
    cyc_cnt <= cyc_cnt + 1;
    if (map_enable) map_q <= map_state_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (!reset && map_enable) begin
      wr_cyc.push_back(cyc_cnt);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: map_state_in 0x%0h, expected no write", map_state_in);
      end else begin
        check("map_state_in", 32'(map_state_in), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic model_commit();
    logic [NB-1:0] nx;
    nx = life_next(m_map);
    exp_q.push_back(nx);
    m_stable  = (nx == m_map);
    m_extinct = (nx == '0);
    if (m_gen != '1) m_gen++;
    m_map = nx;
  endtask

  task automatic model_load(input logic [NB-1:0] p);
    exp_q.push_back(p);
    m_map = p;
    m_gen = '0;
    m_stable = 0;
    m_extinct = 0;
    m_halted = 0;
  endtask

  task automatic check_flags(input string name);
    check({name, "_generation"}, 32'(generation), 32'(m_gen));
    check({name, "_stable"},     32'(stable),     32'(m_stable));
    check({name, "_extinct"},    32'(extinct),    32'(m_extinct));
    check({name, "_halted"},     32'(halted),     32'(m_halted));
  endtask

  task automatic do_load(input logic [NB-1:0] p);
    model_load(p);
    load_req = 1'b1;
    load_pattern = p;
    cyc();
    load_req = 1'b0;
    check("load_latency", 32'(map_enable), 32'(1));
    cyc();
  endtask

  task automatic do_step();
    if (!m_halted) model_commit();
    step = 1'b1;
    cyc();
    step = 1'b0;
    check("step_latency", 32'(map_enable), 32'(!m_halted));
    cyc();
  endtask

  // len is kept off multiples of TD so run never drops in a commit cycle
  task automatic do_run(input int len, input bit with_step);
    if (!m_halted) begin
      for (int k = 1; k <= len / TD; k++) begin
        model_commit();
        if (m_stable || m_extinct) begin
          m_halted = 1;
          break;
        end
      end
    end
    run = 1'b1;
    step = with_step;
    cyc();
    step = 1'b0;
    if (with_step) check("run_beats_step", 32'(map_enable), 32'(0));
    repeat (len - 1) cyc();
    run = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len;
    repeat (2) @(posedge clock);
    #1;
    check("rst_map_enable", 32'(map_enable), 32'(0));
    check("rst_generation", 32'(generation), 32'(0));
    check("rst_stable",     32'(stable),     32'(0));
    check("rst_extinct",    32'(extinct),    32'(0));
    check("rst_halted",     32'(halted),     32'(0));
    reset = 1'b0;
    cyc();

    do_load(16'h0660);
    check_flags("load_block");

    do_run(9, 0);
    check_flags("auto_halt");
    check("halt_stable_set", 32'(stable), 32'(1));
    do_step();
    check_flags("halt_ignores_step");

    do_load(16'h0001);
    do_run(7, 0);
    check_flags("extinction");
    check("extinct_set", 32'(extinct), 32'(1));

    do_load(16'h0E00);
    check_flags("load_clears_flags");
    check("idle_passthru", 32'(map_state_in), 32'(16'h4440));

    wr_cyc.delete();
    do_run(17, 0);
    check_flags("blinker_run");
    check("blinker_commits", 32'(wr_cyc.size()), 32'(4));
    for (int i = 1; i < wr_cyc.size(); i++)
      check("blinker_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(TD));

    do_step();
    do_run(5, 1);
    check_flags("run_beats_step");

    // load_req lands on the divider tick, one cycle before the commit would be written
    run = 1'b1;
    repeat (3) cyc();
    model_load(16'h0660);
    load_req = 1'b1;
    load_pattern = 16'h0660;
    cyc();
    load_req = 1'b0;
    run = 1'b0;
    check("load_vs_tick_latency", 32'(map_enable), 32'(1));
    cyc();
    cyc();
    check_flags("load_vs_tick");

    do_load(16'h0E00);
    do_step();
    do_step();
    run = 1'b1;
    repeat (3) cyc();
    #2;
    reset = 1'b1;
    run = 1'b0;
    #1;
    check("midrun_rst_map_enable", 32'(map_enable), 32'(0));
    check("midrun_rst_generation", 32'(generation), 32'(0));
    check("midrun_rst_stable",     32'(stable),     32'(0));
    check("midrun_rst_extinct",    32'(extinct),    32'(0));
    check("midrun_rst_halted",     32'(halted),     32'(0));
    m_gen = '0;
    m_stable = 0;
    m_extinct = 0;
    m_halted = 0;
    cyc();
    reset = 1'b0;
    repeat (10) cyc();
    check_flags("post_reset_quiet");
    do_step();
    check_flags("post_reset_step");

    for (int it = 0; it < 20; it++) begin
      do_load(16'($urandom()));
      repeat ($urandom_range(0, 3)) do_step();
      len = $urandom_range(1, 20);
      if (len % TD == 0) len++;
      do_run(len, 0);
      check_flags("rand_run");
      if ($urandom_range(0, 1) == 1) begin
        do_step();
        check_flags("rand_step");
      end
    end

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
